// File: rtl/sd_pkg.sv
// Shared definitions for the SD card SPI scheduler: FSM state encoding and
// the level driven onto the card pins whenever no engine owns them.
package sd_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    INIT  = 3'd1,
    GAPW  = 3'd2,
    IDLE  = 3'd3,
    ISSUE = 3'd4,
    BUSY  = 3'd5
  } state_e;

  localparam logic SD_IDLE_LVL = 1'b1;
  localparam int   HOLD_CYCLES = 4;
  localparam int   CNT_W       = 16;

endpackage

// File: rtl/sd_spi_sched_if.sv
// Requester-side bus of the scheduler: two level requests with their sector
// addresses, and the grant / completion / failure indications returned.
interface sd_spi_sched_if;

  logic        req0;
  logic        req1;
  logic [31:0] sec0;
  logic [31:0] sec1;
  logic        gnt0;
  logic        gnt1;
  logic        ack0;
  logic        ack1;
  logic        fail0;
  logic        fail1;

  modport master (
    output req0, req1, sec0, sec1,
    input  gnt0, gnt1, ack0, ack1, fail0, fail1
  );

  modport slave (
    input  req0, req1, sec0, sec1,
    output gnt0, gnt1, ack0, ack1, fail0, fail1
  );

endinterface

// File: rtl/sd_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from the request vector, and a
// last-grant register that only moves when the caller actually takes a grant.
module sd_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    gnt = req;
    if (&req) gnt = last_q ? 2'b01 : 2'b10;
    last_d = last_q;
    if (take && (|gnt)) last_d = gnt[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/sd_spi_sched.sv
// SD card SPI owner: holds and releases the init engine, then arbitrates
// sector reads between two requesters with watchdog, retries and re-init.
module sd_spi_sched
  import sd_pkg::*;
#(
  parameter logic [19:0] TIMEOUT   = 20'd1000000,
  parameter int          MAX_RETRY = 3,
  parameter int          GAP       = 8
) (
  input  logic          SD_clk,
  input  logic          rst,
  input  logic          init_o,
  input  logic          init_cs,
  input  logic          init_din,
  output logic          init_rst_n,
  output logic          rd_start,
  output logic [31:0]   rd_sec,
  input  logic          rd_cs,
  input  logic          rd_din,
  input  logic          rd_done,
  input  logic          rd_err,
  sd_spi_sched_if.slave req_bus,
  output logic          SD_cs,
  output logic          SD_datain,
  output logic          ready
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [19:0]        wdog_q, wdog_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pend_q, pend_d;
  logic               owner_q, owner_d;
  logic [31:0]        sec_q, sec_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         fail_q, fail_d;
  logic               rd_start_q, rd_start_d;
  logic [31:0]        rd_sec_q, rd_sec_d;
  logic               sd_cs_q, sd_cs_d;
  logic               sd_din_q, sd_din_d;

  logic [1:0] arb_gnt;
  logic       take;
  logic       done_ev;
  logic       fail_ev;
  logic       attempt_fail;

  sd_rr_arb2 u_arb (
    .clk  (SD_clk),
    .rst  (rst),
    .req  ({req_bus.req1, req_bus.req0}),
    .take (take),
    .gnt  (arb_gnt)
  );

  always_ff @(posedge SD_clk) begin
    if (rst) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      wdog_q     <= '0;
      retry_q    <= '0;
      pend_q     <= 1'b0;
      owner_q    <= 1'b0;
      sec_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      fail_q     <= '0;
      rd_start_q <= 1'b0;
      rd_sec_q   <= '0;
      sd_cs_q    <= SD_IDLE_LVL;
      sd_din_q   <= SD_IDLE_LVL;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdog_q     <= wdog_d;
      retry_q    <= retry_d;
      pend_q     <= pend_d;
      owner_q    <= owner_d;
      sec_q      <= sec_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      fail_q     <= fail_d;
      rd_start_q <= rd_start_d;
      rd_sec_q   <= rd_sec_d;
      sd_cs_q    <= sd_cs_d;
      sd_din_q   <= sd_din_d;
    end
  end

  // A retry goes back through the command gap and re-issues with the grant
  // still held; pend_q marks that GAPW must return to ISSUE, not IDLE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    wdog_d       = wdog_q;
    retry_d      = retry_q;
    pend_d       = pend_q;
    take         = 1'b0;
    done_ev      = 1'b0;
    fail_ev      = 1'b0;
    attempt_fail = rd_err || (wdog_q == (TIMEOUT - 20'd1));
    case (state_q)
      HOLD:  if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = INIT;
      INIT:  if (init_o) state_d = GAPW;
      GAPW:  if (cnt_q == CNT_W'(GAP - 1)) state_d = pend_q ? ISSUE : IDLE;
      IDLE: begin
        if (|arb_gnt) begin
          take    = 1'b1;
          retry_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        pend_d  = 1'b0;
        state_d = BUSY;
      end
      BUSY: begin
        if (wdog_q != '1) wdog_d = wdog_q + 20'd1;
        if (rd_done) begin
          done_ev = 1'b1;
          state_d = GAPW;
        end else if (attempt_fail) begin
          if ((int'(retry_q) + 1) < MAX_RETRY) begin
            retry_d = retry_q + RETRY_W'(1);
            pend_d  = 1'b1;
            state_d = GAPW;
          end else begin
            fail_ev = 1'b1;
            state_d = HOLD;
          end
        end
      end
      default: state_d = HOLD;
    endcase
    // Losing the card outside init abandons whatever request is owned.
    if ((state_q inside {GAPW, IDLE, ISSUE, BUSY}) && !init_o) begin
      state_d = HOLD;
      take    = 1'b0;
      done_ev = 1'b0;
      pend_d  = 1'b0;
      fail_ev = |gnt_q;
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    sec_d      = sec_q;
    ack_d      = '0;
    fail_d     = '0;
    rd_start_d = (state_q == ISSUE) && (state_d == BUSY);
    rd_sec_d   = rd_start_d ? sec_q : rd_sec_q;
    if (take) begin
      gnt_d   = arb_gnt;
      owner_d = arb_gnt[1];
      sec_d   = arb_gnt[1] ? req_bus.sec1 : req_bus.sec0;
    end
    if (done_ev || fail_ev) begin
      gnt_d          = '0;
      ack_d[owner_q] = 1'b1;
      if (fail_ev) fail_d[owner_q] = 1'b1;
    end
    case (state_q)
      INIT: begin
        sd_cs_d  = init_cs;
        sd_din_d = init_din;
      end
      BUSY: begin
        sd_cs_d  = rd_cs;
        sd_din_d = rd_din;
      end
      default: begin
        sd_cs_d  = SD_IDLE_LVL;
        sd_din_d = SD_IDLE_LVL;
      end
    endcase
  end

  assign init_rst_n    = (state_q != HOLD);
  assign ready         = (state_q == IDLE);
  assign rd_start      = rd_start_q;
  assign rd_sec        = rd_sec_q;
  assign SD_cs         = sd_cs_q;
  assign SD_datain     = sd_din_q;
  assign req_bus.gnt0  = gnt_q[0];
  assign req_bus.gnt1  = gnt_q[1];
  assign req_bus.ack0  = ack_q[0];
  assign req_bus.ack1  = ack_q[1];
  assign req_bus.fail0 = fail_q[0];
  assign req_bus.fail1 = fail_q[1];

endmodule

// File: tb/tb_sd_spi_sched.sv
// Directed bench for sd_spi_sched: power-up, arbitration, retries, watchdog,
// init loss and mid-transfer reset, with hand-computed cycle expectations.
module tb_sd_spi_sched;

  localparam logic [19:0] TO   = 20'd1000;
  localparam int          MAXR = 3;
  localparam int          GAPC = 8;

  logic        SD_clk = 1'b0;
  logic        rst, init_o, init_cs, init_din, rd_cs, rd_din, rd_done, rd_err;
  logic        init_rst_n, rd_start, SD_cs, SD_datain, ready;
  logic [31:0] rd_sec;
  int          checks = 0;
  int          failures = 0;

  sd_spi_sched_if bus ();

  sd_spi_sched #(.TIMEOUT(TO), .MAX_RETRY(MAXR), .GAP(GAPC)) dut (
    .SD_clk     (SD_clk),
    .rst        (rst),
    .init_o     (init_o),
    .init_cs    (init_cs),
    .init_din   (init_din),
    .init_rst_n (init_rst_n),
    .rd_start   (rd_start),
    .rd_sec     (rd_sec),
    .rd_cs      (rd_cs),
    .rd_din     (rd_din),
    .rd_done    (rd_done),
    .rd_err     (rd_err),
    .req_bus    (bus),
    .SD_cs      (SD_cs),
    .SD_datain  (SD_datain),
    .ready      (ready)
  );

  always #5 SD_clk = ~SD_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic tick();
    @(posedge SD_clk);
    #1;
  endtask

  task automatic wait_start(input int budget, output bit seen, output int waited);
    seen = 0;
    waited = 0;
    while (!seen && waited < budget) begin
      tick();
      waited++;
      if (rd_start === 1'b1) seen = 1;
    end
  endtask

  task automatic wait_ready(input int budget, output bit seen, output int waited);
    seen = 0;
    waited = 0;
    while (!seen && waited < budget) begin
      tick();
      waited++;
      if (ready === 1'b1) seen = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1; init_o = 0; init_cs = 0; init_din = 1; rd_cs = 0; rd_din = 0;
    rd_done = 0; rd_err = 0;
    bus.req0 = 0; bus.req1 = 0; bus.sec0 = '0; bus.sec1 = '0;
    tick();
    tick();
    checks++; if (init_rst_n !== 1'b0) begin failures++; $display("[TB] FAIL reset_init_rst_n got=%b exp=0", init_rst_n); end
    checks++; if ({SD_cs, SD_datain} !== 2'b11) begin failures++; $display("[TB] FAIL reset_pins got=%b exp=11", {SD_cs, SD_datain}); end
    checks++; if (ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (rd_start !== 1'b0 || rd_sec !== 32'h0) begin failures++; $display("[TB] FAIL reset_rd got=%b/%h exp=0/0", rd_start, rd_sec); end
    checks++; if ({bus.gnt1, bus.gnt0, bus.ack1, bus.ack0, bus.fail1, bus.fail0} !== 6'b0) begin
      failures++; $display("[TB] FAIL reset_req_bus got=%b exp=000000", {bus.gnt1, bus.gnt0, bus.ack1, bus.ack0, bus.fail1, bus.fail0});
    end
  endtask

  task automatic test_powerup();
    bit rdy_seen;
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (init_rst_n !== 1'b0) begin failures++; $display("[TB] FAIL hold_cycle%0d got=%b exp=0", i, init_rst_n); end
    end
    tick();
    checks++; if (init_rst_n !== 1'b1) begin failures++; $display("[TB] FAIL init_release got=%b exp=1", init_rst_n); end
    checks++; if (SD_cs !== 1'b1) begin failures++; $display("[TB] FAIL cs_before_init got=%b exp=1", SD_cs); end
    tick();
    checks++; if ({SD_cs, SD_datain} !== 2'b01) begin failures++; $display("[TB] FAIL init_pin_mux got=%b exp=01", {SD_cs, SD_datain}); end
    rdy_seen = 0;
    repeat (43) begin
      tick();
      if (ready !== 1'b0) rdy_seen = 1;
    end
    checks++; if (rdy_seen) begin failures++; $display("[TB] FAIL ready_during_init got=1 exp=0"); end
    init_o = 1;
    repeat (GAPC) begin
      tick();
      if (ready !== 1'b0) rdy_seen = 1;
    end
    checks++; if (rdy_seen) begin failures++; $display("[TB] FAIL ready_during_gap got=1 exp=0"); end
    tick();
    checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_gap got=%b exp=1", ready); end
  endtask

  task automatic test_contention();
    int exp_w;
    bit seen;
    int n;
    bus.sec0 = 32'h0000_0100;
    bus.sec1 = 32'h0000_0200;
    bus.req0 = 1;
    bus.req1 = 1;
    for (int k = 0; k < 4; k++) begin
      exp_w = k % 2;
      tick();
      checks++; if ({bus.gnt1, bus.gnt0} !== ((exp_w == 1) ? 2'b10 : 2'b01)) begin
        failures++; $display("[TB] FAIL rr_grant%0d got=%b exp_winner=%0d", k, {bus.gnt1, bus.gnt0}, exp_w);
      end
      tick();
      checks++; if (rd_start !== 1'b1 || rd_sec !== ((exp_w == 1) ? 32'h200 : 32'h100)) begin
        failures++; $display("[TB] FAIL rr_issue%0d got=%b/%h exp_winner=%0d", k, rd_start, rd_sec, exp_w);
      end
      repeat (5) tick();
      rd_done = 1;
      tick();
      rd_done = 0;
      checks++; if ({bus.ack1, bus.ack0, bus.gnt1, bus.gnt0} !== ((exp_w == 1) ? 4'b1000 : 4'b0100)) begin
        failures++; $display("[TB] FAIL rr_ack%0d got=%b exp_winner=%0d", k, {bus.ack1, bus.ack0, bus.gnt1, bus.gnt0}, exp_w);
      end
      if (k == 3) begin
        bus.req0 = 0;
        bus.req1 = 0;
      end
      wait_ready(50, seen, n);
      checks++; if (!seen || n != GAPC) begin failures++; $display("[TB] FAIL rr_gap%0d got=%0d exp=%0d", k, n, GAPC); end
    end
  endtask

  task automatic test_single_read();
    int extra;
    bit seen;
    int n;
    bus.sec0 = 32'h0000_2000;
    bus.req0 = 1;
    tick();
    checks++; if ({bus.gnt1, bus.gnt0, ready, rd_start} !== 4'b0100) begin
      failures++; $display("[TB] FAIL single_grant got=%b exp=0100", {bus.gnt1, bus.gnt0, ready, rd_start});
    end
    tick();
    checks++; if (rd_start !== 1'b1 || rd_sec !== 32'h0000_2000) begin
      failures++; $display("[TB] FAIL single_issue got=%b/%h exp=1/00002000", rd_start, rd_sec);
    end
    bus.req0 = 0;
    tick();
    checks++; if ({SD_cs, SD_datain, rd_start} !== 3'b000) begin
      failures++; $display("[TB] FAIL busy_pin_mux got=%b exp=000", {SD_cs, SD_datain, rd_start});
    end
    extra = 0;
    repeat (598) begin
      tick();
      if (rd_start === 1'b1 || bus.ack0 === 1'b1) extra++;
    end
    rd_done = 1;
    tick();
    rd_done = 0;
    checks++; if ({bus.ack0, bus.fail0, bus.gnt0} !== 3'b100) begin
      failures++; $display("[TB] FAIL single_ack got=%b exp=100", {bus.ack0, bus.fail0, bus.gnt0});
    end
    tick();
    checks++; if (bus.ack0 !== 1'b0 || extra != 0) begin
      failures++; $display("[TB] FAIL single_pulses got=ack%b/extra%0d exp=ack0/extra0", bus.ack0, extra);
    end
    wait_ready(50, seen, n);
    checks++; if (!seen) begin failures++; $display("[TB] FAIL single_ready got=0 exp=1"); end
  endtask

  task automatic test_retry();
    int starts;
    bit seen;
    int n;
    bus.sec0 = 32'h0000_3000;
    bus.req0 = 1;
    starts = 0;
    for (int a = 0; a < 3; a++) begin
      wait_start((a == 0) ? 5 : 30, seen, n);
      if (seen) starts++;
      checks++; if (!seen || rd_sec !== 32'h0000_3000 || (a > 0 && n != GAPC + 1)) begin
        failures++; $display("[TB] FAIL retry_issue%0d got=seen%0d/%h/%0d exp=1/00003000/%0d", a, seen, rd_sec, n, GAPC + 1);
      end
      repeat (3) tick();
      if (a < 2) rd_err = 1;
      else       rd_done = 1;
      tick();
      rd_err = 0;
      rd_done = 0;
      if (a < 2) begin
        checks++; if ({bus.ack0, bus.gnt0} !== 2'b01) begin
          failures++; $display("[TB] FAIL retry_hold%0d got=%b exp=01", a, {bus.ack0, bus.gnt0});
        end
      end
    end
    bus.req0 = 0;
    checks++; if ({bus.ack0, bus.fail0, bus.gnt0} !== 3'b100 || starts != 3) begin
      failures++; $display("[TB] FAIL retry_final got=%b/starts%0d exp=100/starts3", {bus.ack0, bus.fail0, bus.gnt0}, starts);
    end
    wait_ready(50, seen, n);
  endtask

  task automatic test_done_and_err();
    bit seen;
    int n;
    bus.sec0 = 32'h0000_0005;
    bus.req0 = 1;
    wait_start(5, seen, n);
    repeat (2) tick();
    rd_done = 1;
    rd_err = 1;
    tick();
    rd_done = 0;
    rd_err = 0;
    bus.req0 = 0;
    checks++; if ({bus.ack0, bus.fail0} !== 2'b10) begin
      failures++; $display("[TB] FAIL done_wins_ack got=%b exp=10", {bus.ack0, bus.fail0});
    end
    wait_ready(50, seen, n);
    checks++; if (!seen || n != GAPC) begin failures++; $display("[TB] FAIL done_wins_gap got=%0d exp=%0d", n, GAPC); end
  endtask

  task automatic test_timeout();
    int st[3];
    int starts, cyc, ack_t, low;
    bit ack_seen, fail_at_ack, rst_n_at_ack, seen;
    int n;
    bus.sec1 = 32'h0000_4000;
    bus.req1 = 1;
    wait_start(5, seen, n);
    starts = seen ? 1 : 0;
    st[0] = 0;
    cyc = 0;
    ack_seen = 0;
    ack_t = 0;
    fail_at_ack = 0;
    rst_n_at_ack = 1;
    while (!ack_seen && cyc < 5000) begin
      tick();
      cyc++;
      if (rd_start === 1'b1) begin
        if (starts < 3) st[starts] = cyc;
        starts++;
      end
      if (bus.ack1 === 1'b1) begin
        ack_seen = 1;
        ack_t = cyc;
        fail_at_ack = bus.fail1;
        rst_n_at_ack = init_rst_n;
      end
    end
    bus.req1 = 0;
    init_o = 0;
    checks++; if (!ack_seen || starts != MAXR) begin
      failures++; $display("[TB] FAIL timeout_attempts got=ack%0d/starts%0d exp=ack1/starts%0d", ack_seen, starts, MAXR);
    end
    checks++; if (starts >= 2 && st[1] - st[0] != int'(TO) + GAPC + 1) begin
      failures++; $display("[TB] FAIL timeout_spacing got=%0d exp=%0d", st[1] - st[0], int'(TO) + GAPC + 1);
    end
    checks++; if (starts == 3 && ack_t - st[2] != int'(TO)) begin
      failures++; $display("[TB] FAIL timeout_abort_time got=%0d exp=%0d", ack_t - st[2], int'(TO));
    end
    checks++; if (fail_at_ack !== 1'b1 || rst_n_at_ack !== 1'b0) begin
      failures++; $display("[TB] FAIL timeout_fail got=fail%b/rst_n%b exp=fail1/rst_n0", fail_at_ack, rst_n_at_ack);
    end
    low = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (init_rst_n !== 1'b0) break;
      low++;
    end
    checks++; if (low != 4) begin failures++; $display("[TB] FAIL reinit_hold got=%0d exp=4", low); end
    repeat (5) tick();
    init_o = 1;
    wait_ready(50, seen, n);
    checks++; if (!seen) begin failures++; $display("[TB] FAIL reinit_ready got=0 exp=1"); end
  endtask

  task automatic test_init_drop();
    bit seen;
    int n;
    bus.sec1 = 32'h0000_0050;
    bus.req1 = 1;
    wait_start(5, seen, n);
    repeat (3) tick();
    init_o = 0;
    tick();
    bus.req1 = 0;
    checks++; if ({bus.ack1, bus.fail1, bus.gnt1, init_rst_n} !== 4'b1100) begin
      failures++; $display("[TB] FAIL init_drop_abort got=%b exp=1100", {bus.ack1, bus.fail1, bus.gnt1, init_rst_n});
    end
    repeat (6) tick();
    init_o = 1;
    wait_ready(50, seen, n);
    checks++; if (!seen) begin failures++; $display("[TB] FAIL init_drop_ready got=0 exp=1"); end
  endtask

  task automatic test_reset_mid_busy();
    bit seen;
    int n;
    bus.sec0 = 32'h0000_0060;
    bus.req0 = 1;
    wait_start(5, seen, n);
    tick();
    checks++; if (SD_cs !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy_cs got=%b exp=0", SD_cs); end
    rst = 1;
    tick();
    checks++; if ({SD_cs, SD_datain, bus.gnt0, init_rst_n, rd_start} !== 5'b11000) begin
      failures++; $display("[TB] FAIL mid_busy_reset got=%b exp=11000", {SD_cs, SD_datain, bus.gnt0, init_rst_n, rd_start});
    end
    rst = 0;
    bus.req0 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_contention();
    test_single_read();
    test_retry();
    test_done_and_err();
    test_timeout();
    test_init_drop();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
